// File: rtl/bit4_timer_pkg.sv
// Shared definitions for the down-counting timer: state encoding and default width.
package bit4_timer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bit4_down_timer.sv
// Loadable down-counting timer with one-shot or periodic mode and a single-cycle done pulse.
module bit4_down_timer
  import bit4_timer_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic             abort,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q,   done_d;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = load_value;
          if (load_value != '0) begin
            reload_d = load_value;
            state_d  = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        // Terminal count is caught at 1 so the counter never wraps below zero.
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (enable) begin
          if (count_q == WIDTH'(1)) begin
            done_d = 1'b1;
            if (AUTO_RELOAD) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_bit4_down_timer.sv
// Self-checking bench: a one-shot instance driven from a vector table, plus hand sequences for
// back-to-back restart and a periodic (auto-reload) instance.
module tb_bit4_down_timer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // One-shot instance
  logic       os_reset = 1'b0, os_start = 1'b0, os_enable = 1'b0, os_abort = 1'b0;
  logic [3:0] os_load  = 4'd0;
  logic [3:0] os_count;
  logic       os_busy, os_done;

  // Periodic instance
  logic       ar_reset = 1'b0, ar_start = 1'b0, ar_enable = 1'b0, ar_abort = 1'b0;
  logic [3:0] ar_load  = 4'd0;
  logic [3:0] ar_count;
  logic       ar_busy, ar_done;

  bit4_down_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_os (
    .clk        (clk),
    .reset      (os_reset),
    .start      (os_start),
    .enable     (os_enable),
    .abort      (os_abort),
    .load_value (os_load),
    .count      (os_count),
    .busy       (os_busy),
    .done       (os_done)
  );

  bit4_down_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_ar (
    .clk        (clk),
    .reset      (ar_reset),
    .start      (ar_start),
    .enable     (ar_enable),
    .abort      (ar_abort),
    .load_value (ar_load),
    .count      (ar_count),
    .busy       (ar_busy),
    .done       (ar_done)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic       enable;
    logic       abort;
    logic [3:0] load;
    logic [3:0] exp_count;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic add(input logic rst, input logic st, input logic en, input logic ab,
                     input logic [3:0] ld, input logic [3:0] ec, input logic eb, input logic ed);
    vec_t v;
    v.rst = rst; v.start = st; v.enable = en; v.abort = ab; v.load = ld;
    v.exp_count = ec; v.exp_busy = eb; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  // Drive one-shot inputs, take one edge, sample 1 time unit after it.
  task automatic step_os(input logic rst, input logic st, input logic en, input logic ab,
                         input logic [3:0] ld);
    os_reset = rst; os_start = st; os_enable = en; os_abort = ab; os_load = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic step_ar(input logic rst, input logic st, input logic en, input logic ab,
                         input logic [3:0] ld);
    ar_reset = rst; ar_start = st; ar_enable = en; ar_abort = ab; ar_load = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic check_os(input string tag, input int ec, input int eb, input int ed);
    check({tag, ".count"}, int'(os_count), ec);
    check({tag, ".busy"},  int'(os_busy),  eb);
    check({tag, ".done"},  int'(os_done),  ed);
  endtask

  task automatic check_ar(input string tag, input int ec, input int eb, input int ed);
    check({tag, ".count"}, int'(ar_count), ec);
    check({tag, ".busy"},  int'(ar_busy),  eb);
    check({tag, ".done"},  int'(ar_done),  ed);
  endtask

  initial begin
    // ---- vector table for the one-shot instance ----
    //   rst st en ab load  count busy done
    add(1, 0, 0, 0, 4'd0,  4'd0, 0, 0);   // reset
    // load 5, enable high: 5,4,3,2,1 then done with count 0
    add(0, 1, 1, 0, 4'd5,  4'd5, 1, 0);
    add(0, 0, 1, 0, 4'd5,  4'd4, 1, 0);
    add(0, 0, 1, 0, 4'd5,  4'd3, 1, 0);
    add(0, 0, 1, 0, 4'd5,  4'd2, 1, 0);
    add(0, 0, 1, 0, 4'd5,  4'd1, 1, 0);
    add(0, 0, 1, 0, 4'd5,  4'd0, 0, 1);
    add(0, 0, 1, 0, 4'd5,  4'd0, 0, 0);   // done lasts one cycle; enable ignored in IDLE
    // load 4, enable toggling: each decrement takes two cycles
    add(0, 1, 0, 0, 4'd4,  4'd4, 1, 0);
    add(0, 0, 1, 0, 4'd9,  4'd3, 1, 0);   // load_value changes have no effect while running
    add(0, 0, 0, 0, 4'd9,  4'd3, 1, 0);
    add(0, 0, 1, 0, 4'd9,  4'd2, 1, 0);
    add(0, 0, 0, 0, 4'd9,  4'd2, 1, 0);
    add(0, 0, 1, 0, 4'd9,  4'd1, 1, 0);
    add(0, 0, 0, 0, 4'd9,  4'd1, 1, 0);
    add(0, 0, 1, 0, 4'd9,  4'd0, 0, 1);
    add(0, 0, 0, 1, 4'd9,  4'd0, 0, 0);   // abort ignored in IDLE
    // abort at count 2 with start on the same cycle
    add(0, 1, 1, 0, 4'd5,  4'd5, 1, 0);
    add(0, 0, 1, 0, 4'd5,  4'd4, 1, 0);
    add(0, 0, 1, 0, 4'd5,  4'd3, 1, 0);
    add(0, 0, 1, 0, 4'd5,  4'd2, 1, 0);
    add(0, 1, 1, 1, 4'd9,  4'd0, 0, 0);   // abort wins, start ignored
    add(0, 0, 1, 0, 4'd9,  4'd0, 0, 0);   // no restart
    // zero load: done next cycle, never busy
    add(0, 1, 0, 0, 4'd0,  4'd0, 0, 1);
    add(0, 0, 0, 0, 4'd0,  4'd0, 0, 0);
    // terminal edge in RUN ignores start
    add(0, 1, 1, 0, 4'd1,  4'd1, 1, 0);
    add(0, 1, 1, 0, 4'd7,  4'd0, 0, 1);
    // reset at count 1 with enable high suppresses done
    add(0, 0, 1, 0, 4'd2,  4'd0, 0, 0);
    add(0, 1, 1, 0, 4'd2,  4'd2, 1, 0);
    add(0, 0, 1, 0, 4'd2,  4'd1, 1, 0);
    add(1, 0, 1, 0, 4'd2,  4'd0, 0, 0);
    add(0, 0, 1, 0, 4'd2,  4'd0, 0, 0);

    foreach (vecs[i]) begin
      step_os(vecs[i].rst, vecs[i].start, vecs[i].enable, vecs[i].abort, vecs[i].load);
      check_os($sformatf("vec%0d", i), int'(vecs[i].exp_count),
               int'(vecs[i].exp_busy), int'(vecs[i].exp_done));
    end

    // ---- back-to-back: load 15, restart with 2 on the done cycle ----
    step_os(0, 1, 1, 0, 4'd15);
    check_os("b2b.load", 15, 1, 0);
    for (int k = 14; k >= 1; k--) begin
      step_os(0, 0, 1, 0, 4'd15);
      check_os($sformatf("b2b.c%0d", k), k, 1, 0);
    end
    step_os(0, 0, 1, 0, 4'd15);
    check_os("b2b.term", 0, 0, 1);
    step_os(0, 1, 1, 0, 4'd2);             // start while done is high
    check_os("b2b.reload", 2, 1, 0);
    step_os(0, 0, 1, 0, 4'd2);
    check_os("b2b.r1", 1, 1, 0);
    step_os(0, 0, 1, 0, 4'd2);
    check_os("b2b.rdone", 0, 0, 1);

    // ---- periodic instance: load 3, enable high for 12 cycles ----
    step_ar(1, 0, 0, 0, 4'd0);
    check_ar("ar.reset", 0, 0, 0);
    step_ar(0, 1, 1, 0, 4'd3);
    check_ar("ar.load", 3, 1, 0);
    for (int k = 1; k <= 12; k++) begin
      step_ar(0, 0, 1, 0, 4'd7);           // changed load_value must not affect reload
      check_ar($sformatf("ar.k%0d", k), (k % 3 == 0) ? 3 : 3 - (k % 3), 1, (k % 3 == 0) ? 1 : 0);
    end
    step_ar(0, 0, 0, 1, 4'd7);
    check_ar("ar.abort", 0, 0, 0);
    // periodic with N=1: done every cycle
    step_ar(0, 1, 1, 0, 4'd1);
    check_ar("ar1.load", 1, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      step_ar(0, 0, 1, 0, 4'd1);
      check_ar($sformatf("ar1.k%0d", k), 1, 1, 1);
    end
    step_ar(0, 0, 0, 0, 4'd1);
    check_ar("ar1.hold", 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
